// File: rtl/jedro_1_fetch.sv
// ---------------------------------------------------------------------------
// jedro_1_fetch : instruction prefetch unit with redirect and skid FIFO
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module jedro_1_fetch #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0,
    parameter int                    FIFO_DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  jmp_valid_i,
    input  logic [ADDR_WIDTH-1:0] jmp_addr_i,
    output logic                  instr_valid_o,
    input  logic                  instr_ready_i,
    output logic [DATA_WIDTH-1:0] instr_o,
    output logic [ADDR_WIDTH-1:0] instr_addr_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {BOOT = 1'b0, RUN = 1'b1} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   pc;
    logic                    inflight;
    logic [ADDR_WIDTH-1:0]   inflight_addr;
    logic [DATA_WIDTH-1:0]   fifo_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]   fifo_addr [FIFO_DEPTH];
    logic [PW-1:0]           rd_ptr;
    logic [PW-1:0]           wr_ptr;
    logic [CW-1:0]           count;

    logic                    redirect;
    logic                    pop;
    logic                    push;
    logic [CW:0]             occupancy;
    logic [ADDR_WIDTH-1:0]   jmp_target;

    always_comb begin
        jmp_target    = {jmp_addr_i[ADDR_WIDTH-1:2], 2'b00};
        redirect      = (state == RUN) && jmp_valid_i;
        instr_valid_o = (count != '0);
        // A redirect discards the head, so it never counts as a delivery.
        pop           = instr_valid_o && instr_ready_i && !redirect;
        push          = inflight && !redirect;
        // Slots already promised: buffered + returning next edge - leaving now.
        occupancy     = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(pop);
        mem_en_o      = (state == RUN) && (jmp_valid_i || (occupancy < (CW+1)'(FIFO_DEPTH)));
        mem_addr_o    = redirect ? jmp_target : pc;
        instr_o       = instr_valid_o ? fifo_data[rd_ptr] : '0;
        instr_addr_o  = instr_valid_o ? fifo_addr[rd_ptr] : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state         <= BOOT;
            pc            <= BOOT_ADDR;
            inflight      <= 1'b0;
            inflight_addr <= BOOT_ADDR;
            rd_ptr        <= '0;
            wr_ptr        <= '0;
            count         <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN: begin
                    if (redirect) begin
                        inflight      <= 1'b1;
                        inflight_addr <= jmp_target;
                        pc            <= jmp_target + ADDR_WIDTH'(4);
                        rd_ptr        <= '0;
                        wr_ptr        <= '0;
                        count         <= '0;
                    end else begin
                        inflight <= mem_en_o;
                        if (mem_en_o) begin
                            inflight_addr <= pc;
                            pc            <= pc + ADDR_WIDTH'(4);
                        end
                        if (push) wr_ptr <= wr_ptr + PW'(1);
                        if (pop)  rd_ptr <= rd_ptr + PW'(1);
                        count <= count + CW'(push) - CW'(pop);
                    end
                end
                default: state <= BOOT;
            endcase
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk_i) begin
        if (rstn_i && push) begin
            fifo_data[wr_ptr] <= mem_rdata_i;
            fifo_addr[wr_ptr] <= inflight_addr;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jedro_1_fetch.sv
// ---------------------------------------------------------------------------
// tb_jedro_1_fetch : scoreboard bench, expected stream derived from jump/reset targets
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_jedro_1_fetch;

    localparam int          D     = 4;
    localparam logic [31:0] BOOT  = 32'h0;
    localparam logic [31:0] BOOT2 = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        jmp_valid;
    logic [31:0] jmp_addr;
    logic        instr_ready;
    logic        mem_en;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_addr;

    logic        mem_en2;
    logic [31:0] mem_addr2;
    logic [31:0] mem_rdata2;
    logic        instr_valid2;
    logic [31:0] instr2;
    logic [31:0] instr_addr2;

    jedro_1_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BOOT_ADDR(BOOT), .FIFO_DEPTH(D)) dut (
        .clk_i(clk), .rstn_i(rstn), .mem_en_o(mem_en), .mem_addr_o(mem_addr),
        .mem_rdata_i(mem_rdata), .jmp_valid_i(jmp_valid), .jmp_addr_i(jmp_addr),
        .instr_valid_o(instr_valid), .instr_ready_i(instr_ready),
        .instr_o(instr), .instr_addr_o(instr_addr)
    );

    jedro_1_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BOOT_ADDR(BOOT2), .FIFO_DEPTH(D)) dut2 (
        .clk_i(clk), .rstn_i(rstn), .mem_en_o(mem_en2), .mem_addr_o(mem_addr2),
        .mem_rdata_i(mem_rdata2), .jmp_valid_i(1'b0), .jmp_addr_i(32'h0),
        .instr_valid_o(instr_valid2), .instr_ready_i(1'b1),
        .instr_o(instr2), .instr_addr_o(instr_addr2)
    );

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h13 + ((a >> 2) << 8);
    endfunction

    // One-cycle-latency memories; junk on idle cycles so stale data is visible.
    always @(posedge clk) mem_rdata  <= mem_en  ? rom(mem_addr)  : $urandom;
    always @(posedge clk) mem_rdata2 <= mem_en2 ? rom(mem_addr2) : $urandom;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected delivery stream: consecutive words from the most recent target.
    logic [63:0] exp_q[$];
    logic [31:0] push_addr;

    task automatic topup();
        while (exp_q.size() < 32) begin
            exp_q.push_back({push_addr, rom(push_addr)});
            push_addr = push_addr + 32'd4;
        end
    endtask

    task automatic restart(input logic [31:0] a);
        exp_q.delete();
        push_addr = a;
        topup();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        topup();
    endtask

    int delivered = 0;

    initial begin
        logic        prev_hold;
        logic [31:0] prev_i;
        logic [31:0] prev_a;
        logic [31:0] exp2;
        logic [63:0] e;
        prev_hold = 1'b0;
        prev_i    = '0;
        prev_a    = '0;
        exp2      = BOOT2;
        forever begin
            @(negedge clk);
            if (rstn && instr_valid && instr_ready && !jmp_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_empty: got addr %h expected none", instr_addr);
                end else begin
                    e = exp_q.pop_front();
                    check("deliver_addr", 64'(instr_addr), 64'(e[63:32]));
                    check("deliver_data", 64'(instr), 64'(e[31:0]));
                    delivered++;
                end
            end
            if (!instr_valid) check("idle_zero", {instr_addr, instr}, 64'h0);
            if (prev_hold) begin
                check("hold_valid", 64'(instr_valid), 64'(1));
                check("hold_stable", {instr_addr, instr}, {prev_a, prev_i});
            end
            prev_hold = rstn && instr_valid && !instr_ready && !jmp_valid;
            prev_i    = instr;
            prev_a    = instr_addr;

            if (rstn && instr_valid2) begin
                check("wrap_addr", 64'(instr_addr2), 64'(exp2));
                check("wrap_data", 64'(instr2), 64'(rom(exp2)));
                exp2 = exp2 + 32'd4;
            end
            if (!rstn) exp2 = BOOT2;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int reqs;
        logic prev_rst;
        int r;
        rstn        = 1'b0;
        jmp_valid   = 1'b0;
        jmp_addr    = '0;
        instr_ready = 1'b1;
        restart(BOOT);
        repeat (3) tick();

        @(negedge clk);
        check("rst_mem_en", 64'(mem_en), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(BOOT));
        check("rst_valid", 64'(instr_valid), 64'(0));
        check("rst_instr", {instr_addr, instr}, 64'h0);
        check("rst_mem_addr2", 64'(mem_addr2), 64'(BOOT2));

        // Boot latency and sustained throughput.
        tick();
        rstn = 1'b1;
        lat  = -1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (n == 0) check("boot_no_req", 64'(mem_en), 64'(0));
            if (n == 1) begin
                check("first_req_en", 64'(mem_en), 64'(1));
                check("first_req_addr", 64'(mem_addr), 64'(BOOT));
            end
            if (instr_valid) begin
                lat = n;
                break;
            end
        end
        check("first_valid_cycle", 64'(lat), 64'(3));
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            check("stream_valid", 64'(instr_valid), 64'(1));
        end

        // Stall: exactly D words buffered, fetch stops, head held.
        tick();
        rstn = 1'b0;
        restart(BOOT);
        tick();
        rstn        = 1'b1;
        instr_ready = 1'b0;
        reqs        = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (mem_en) reqs++;
        end
        check("stall_reqs", 64'(reqs), 64'(D));
        check("stall_mem_en", 64'(mem_en), 64'(0));
        check("stall_head", {instr_addr, instr}, {BOOT, rom(BOOT)});
        tick();
        instr_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            check("drain_valid", 64'(instr_valid), 64'(1));
        end

        // Redirect to unaligned target while holding entries.
        tick();
        instr_ready = 1'b0;
        repeat (3) tick();
        jmp_valid = 1'b1;
        jmp_addr  = 32'h23;
        restart(32'h20);
        @(negedge clk);
        check("jmp_mem_en", 64'(mem_en), 64'(1));
        check("jmp_mem_addr", 64'(mem_addr), 64'(32'h20));
        tick();
        jmp_valid   = 1'b0;
        instr_ready = 1'b1;
        @(negedge clk);
        check("jmp_flush_valid", 64'(instr_valid), 64'(0));
        repeat (6) tick();

        // Back-to-back redirects.
        jmp_valid = 1'b1;
        jmp_addr  = 32'h10;
        restart(32'h10);
        tick();
        jmp_addr = 32'h40;
        restart(32'h40);
        tick();
        jmp_valid = 1'b0;
        repeat (8) tick();

        // One-cycle reset mid-stream with the FIFO partly full.
        instr_ready = 1'b0;
        repeat (2) tick();
        rstn = 1'b0;
        restart(BOOT);
        tick();
        rstn        = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        check("rst_mid_valid", 64'(instr_valid), 64'(0));
        repeat (8) tick();

        // Randomized phase.
        delivered = 0;
        prev_rst  = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            tick();
            rstn        = 1'b1;
            jmp_valid   = 1'b0;
            instr_ready = ($urandom % 4) != 0;
            r           = int'($urandom % 200);
            if (r == 0) begin
                rstn = 1'b0;
                restart(BOOT);
                prev_rst = 1'b1;
            end else begin
                if (r < 14 && !prev_rst) begin
                    jmp_valid = 1'b1;
                    jmp_addr  = (($urandom % 8) == 0) ? 32'hFFFF_FFF0 + ($urandom % 16) : $urandom;
                    restart({jmp_addr[31:2], 2'b00});
                end
                prev_rst = 1'b0;
            end
        end
        tick();
        rstn      = 1'b1;
        jmp_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (delivered < 500) begin
            failures++;
            $display("FAIL progress: got %0d deliveries expected at least 500", delivered);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
